cpu_run_monitor: RTL and testbench
==================================

# cpu_run_monitor

Synthesisable run controller and monitor for the pipelined CPU's simulation and bring-up harness. It sequences the core's reset for a parametrised number of cycles. It then watches the core's final address output (PC) and detects halt, defined as the PC being unchanged for N consecutive cycles, or a cycle-budget timeout. It optionally keeps a history of recent distinct PCs that can be read back by index.

## Interface
Parameters:
- ADDR_W, 32, PC width
- CNT_W, 16, cycle counter width
- RESET_CYCLES, 2, cycles core_reset is held after reset release (≥1)
- MAX_CYCLES, 50, RUN-cycle budget before timeout (≥1, < 2^CNT_W)
- HALT_REPEAT, 4, consecutive identical PC samples that mean halt (≥2)
- TRACE_DEPTH, 8, trace entries (power of 2, ≥2)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- pc  in  ADDR_W  core final address, sampled every edge
- core_reset  out  1  reset driven to the core
- state  out  2  0=HOLD, 1=RUN, 2=HALTED, 3=TIMEOUT
- cycle_count  out  CNT_W  RUN cycles elapsed
- halted  out  1  state==HALTED
- timeout  out  1  state==TIMEOUT
- done  out  1  halted|timeout
- last_pc  out  ADDR_W  most recent sampled pc
- trace_idx  in  $clog2(TRACE_DEPTH)  trace read index, 0 = newest
- trace_pc  out  ADDR_W  trace entry at trace_idx (combinational)

## Operation
- Reset (edge with reset=1): state=HOLD, core_reset=1, cycle_count=0, halted/timeout/done=0, last_pc=0, run length=0, hold counter=0, trace entries and write pointer=0.
- HOLD: hold counter increments each edge. On the edge where the counter reaches RESET_CYCLES-1: state→RUN, core_reset→0. pc is not sampled in HOLD.
- RUN, every edge:
  - cycle_count += 1.
  - last_pc <= pc.
  - Run length = 1 if pc != last_pc or this is the first RUN edge; otherwise run length + 1 (saturating at HALT_REPEAT).
  - If the new run length == HALT_REPEAT: state→HALTED.
  - Else if the new cycle_count == MAX_CYCLES: state→TIMEOUT.
  - Halt has priority over timeout on the same edge.
- Trace write: in RUN, when run length restarts at 1, pc is written to trace[wptr] and wptr += 1 mod TRACE_DEPTH. A new entry overwrites the oldest.
- Trace read: trace_pc = trace[(wptr-1-trace_idx) mod TRACE_DEPTH]. Entries never written read 0.
- HALTED and TIMEOUT are terminal until reset:
  - cycle_count, last_pc and trace are frozen.
  - core_reset stays 0.
- Reset asserted in any state returns to reset values on that edge, including mid-HOLD or mid-RUN.

## Timing
- All outputs are registered except trace_pc.
- With reset sampled low first at edge 1, core_reset falls after edge RESET_CYCLES. The first pc sample is at edge RESET_CYCLES+1.
- halted asserts after the edge that samples the HALT_REPEAT-th consecutive identical pc.
- timeout asserts after the MAX_CYCLES-th RUN edge. At that point cycle_count == MAX_CYCLES.
- A trace write is visible on trace_pc (idx 0) the cycle after the write edge.

## Configuration
- CPU_RUN_MON_TRACE_EN defined: trace buffer, write pointer and read mux are built.
- Not defined: no trace storage; trace_pc is tied to 0 and trace_idx is ignored. All other behaviour is identical.

## Test plan
- Parameters are defaults unless stated.
1. Reset held 3 edges then low -> core_reset=1 through edge 2 after release, 0 after it; state HOLD→RUN at that edge; all outputs at reset values while reset is high.
2. pc = 0,4,8,… incrementing every RUN edge -> no halt; after the 50th RUN edge timeout=1, done=1, state=3, cycle_count=50, last_pc=196; values frozen for 10 further edges.
3. pc = 0,4,8,12,12,12,12 -> halted=1 after the 7th RUN edge, state=2, cycle_count=7, last_pc=12; one fewer 12 -> still RUN.
4. With CPU_RUN_MON_TRACE_EN: pc 0,4,8,12 then held -> trace_idx 0..4 read 12,8,4,0,0. Ten distinct pcs 0..36 step 4 -> idx 0=36, idx 7=8 (wrap).
5. Reset asserted at RUN cycle 20 -> next edge state=0, core_reset=1, cycle_count=0, trace reads all 0; the reset sequence then repeats as in scenario 1.
6. MAX_CYCLES=7 with pc as in scenario 3 (halt and budget land on the same edge) -> state=HALTED, timeout=0.

Source files
------------

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: sequences core reset, then watches the core PC to detect
// halt (PC stuck for HALT_REPEAT samples) or a RUN-cycle budget timeout.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   pc                 core final address, sampled every RUN edge
//   core_reset         reset driven to the core (high during HOLD)
//   state              0=HOLD 1=RUN 2=HALTED 3=TIMEOUT
//   cycle_count        RUN cycles elapsed
//   halted/timeout     terminal-state flags, done = halted | timeout
//   last_pc            most recent sampled pc
//   trace_idx          trace read index, 0 = newest distinct pc
//   trace_pc           trace entry at trace_idx (combinational)
//
// Build option: define CPU_RUN_MON_TRACE_EN to build the distinct-PC trace
// buffer; without it trace_pc reads 0 and trace_idx is ignored.

module cpu_run_monitor #(
    parameter int ADDR_W       = 32,
    parameter int CNT_W        = 16,
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 50,
    parameter int HALT_REPEAT  = 4,
    parameter int TRACE_DEPTH  = 8,
    localparam int TIDX_W      = $clog2(TRACE_DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic              core_reset,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              halted,
    output logic              timeout,
    output logic              done,
    output logic [ADDR_W-1:0] last_pc,
    input  logic [TIDX_W-1:0] trace_idx,
    output logic [ADDR_W-1:0] trace_pc
);

    localparam int HW = $clog2(RESET_CYCLES + 1);
    localparam int RW = $clog2(HALT_REPEAT + 1);

    localparam logic [HW-1:0]    HOLD_LAST = HW'(RESET_CYCLES - 1);
    localparam logic [RW-1:0]    RUN_MAX   = RW'(HALT_REPEAT);
    localparam logic [CNT_W-1:0] CYC_MAX   = CNT_W'(MAX_CYCLES);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RUN     = 2'd1,
        S_HALTED  = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [ADDR_W-1:0] last_pc_q, last_pc_d;
    logic [RW-1:0]     run_len_q, run_len_d;
    logic              run_restart;

    // A zero run length marks the first RUN edge, which always restarts.
    assign run_restart = (run_len_q == '0) || (pc != last_pc_q);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_cnt_q <= '0;
            cycle_q    <= '0;
            last_pc_q  <= '0;
            run_len_q  <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            cycle_q    <= cycle_d;
            last_pc_q  <= last_pc_d;
            run_len_q  <= run_len_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        cycle_d    = cycle_q;
        last_pc_d  = last_pc_q;
        run_len_d  = run_len_q;
        unique case (state_q)
            S_HOLD: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cycle_d   = cycle_q + 1'b1;
                last_pc_d = pc;
                if (run_restart) begin
                    run_len_d = RW'(1);
                end else if (run_len_q == RUN_MAX) begin
                    run_len_d = RUN_MAX;
                end else begin
                    run_len_d = run_len_q + 1'b1;
                end
                // Halt wins over timeout on the same edge.
                if (run_len_d == RUN_MAX) begin
                    state_d = S_HALTED;
                end else if (cycle_d == CYC_MAX) begin
                    state_d = S_TIMEOUT;
                end
            end
            default: begin
            end
        endcase
    end

    // Outputs decode registered state only.
    always_comb begin
        state       = state_q;
        core_reset  = (state_q == S_HOLD);
        halted      = (state_q == S_HALTED);
        timeout     = (state_q == S_TIMEOUT);
        done        = halted | timeout;
        cycle_count = cycle_q;
        last_pc     = last_pc_q;
    end

`ifdef CPU_RUN_MON_TRACE_EN
    logic [ADDR_W-1:0] trace_q [TRACE_DEPTH];
    logic [TIDX_W-1:0] wptr_q;
    logic [TIDX_W-1:0] rd_ptr;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                trace_q[i] <= '0;
            end
            wptr_q <= '0;
        end else if (state_q == S_RUN && run_restart) begin
            trace_q[wptr_q] <= pc;
            wptr_q          <= wptr_q + 1'b1;
        end
    end

    // Newest entry sits just behind the write pointer; wraps naturally.
    assign rd_ptr   = wptr_q - TIDX_W'(1) - trace_idx;
    assign trace_pc = trace_q[rd_ptr];
`else
    logic unused_trace_idx;
    assign unused_trace_idx = ^trace_idx;
    assign trace_pc         = '0;
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb_cpu_run_monitor: directed checks of reset sequencing, timeout, halt,
// trace readback and mid-run reset for cpu_run_monitor.

module tb_cpu_run_monitor;

    logic        clock;
    logic        reset;
    logic [31:0] pc;
    logic [2:0]  trace_idx;

    logic        core_reset, halted, timeout, done;
    logic [1:0]  state;
    logic [15:0] cycle_count;
    logic [31:0] last_pc, trace_pc;

    logic        b_core_reset, b_halted, b_timeout, b_done;
    logic [1:0]  b_state;
    logic [15:0] b_cycle_count;
    logic [31:0] b_last_pc, b_trace_pc;

    int tests_run;
    int tests_failed;

    cpu_run_monitor dut (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc),
        .core_reset  (core_reset),
        .state       (state),
        .cycle_count (cycle_count),
        .halted      (halted),
        .timeout     (timeout),
        .done        (done),
        .last_pc     (last_pc),
        .trace_idx   (trace_idx),
        .trace_pc    (trace_pc)
    );

    cpu_run_monitor #(.MAX_CYCLES(7)) dut7 (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc),
        .core_reset  (b_core_reset),
        .state       (b_state),
        .cycle_count (b_cycle_count),
        .halted      (b_halted),
        .timeout     (b_timeout),
        .done        (b_done),
        .last_pc     (b_last_pc),
        .trace_idx   (trace_idx),
        .trace_pc    (b_trace_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset for 3 edges, release, then 2 HOLD edges: next edge samples pc.
    task automatic start_run();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic read_trace(input int idx, input logic [31:0] exp,
                              input string tag);
        trace_idx = 3'(idx);
        #1;
`ifdef CPU_RUN_MON_TRACE_EN
        check(tag, trace_pc, exp);
`else
        check(tag, trace_pc, 0);
`endif
    endtask

    initial begin
        logic [31:0] seq3 [7];
        seq3 = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd12, 32'd12, 32'd12};
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        pc           = 32'h1234;
        trace_idx    = '0;

        // Scenario 1: reset values and HOLD -> RUN sequencing
        repeat (3) tick();
        check("rst_state", state, 0);
        check("rst_core_reset", core_reset, 1);
        check("rst_cycle", cycle_count, 0);
        check("rst_done", {halted, timeout, done}, 0);
        check("rst_last_pc", last_pc, 0);
        read_trace(0, 0, "rst_trace");
        reset = 1'b0;
        tick();
        check("hold1_core_reset", core_reset, 1);
        check("hold1_state", state, 0);
        tick();
        check("hold2_core_reset", core_reset, 0);
        check("hold2_state", state, 1);
        check("hold2_cycle", cycle_count, 0);

        // Scenario 2: incrementing pc runs into the budget
        for (int i = 0; i < 50; i++) begin
            pc = 32'(4 * i);
            tick();
            if (i == 48) begin
                check("to_pre_state", state, 1);
                check("to_pre_cycle", cycle_count, 49);
            end
        end
        check("to_state", state, 3);
        check("to_flags", {halted, timeout, done}, 3'b011);
        check("to_cycle", cycle_count, 50);
        check("to_last_pc", last_pc, 196);
        for (int i = 0; i < 10; i++) begin
            pc = 32'(1000 + 4 * i);
            tick();
        end
        check("to_frz_state", state, 3);
        check("to_frz_cycle", cycle_count, 50);
        check("to_frz_last_pc", last_pc, 196);
        read_trace(0, 196, "to_trace0");
        read_trace(1, 192, "to_trace1");

        // Scenario 3/6: halt detection, one-fewer repeat, shared edge
        start_run();
        for (int i = 0; i < 6; i++) begin
            pc = seq3[i];
            tick();
        end
        check("h6_state", state, 1);
        check("h6_cycle", cycle_count, 6);
        check("h6_b_state", b_state, 1);
        pc = seq3[6];
        tick();
        check("h7_state", state, 2);
        check("h7_flags", {halted, timeout, done}, 3'b101);
        check("h7_cycle", cycle_count, 7);
        check("h7_last_pc", last_pc, 12);
        check("h7_b_state", b_state, 2);
        check("h7_b_timeout", b_timeout, 0);
        pc = 32'd12;
        repeat (3) tick();
        check("h_frz_cycle", cycle_count, 7);
        read_trace(0, 12, "h_trace0");
        read_trace(1, 8, "h_trace1");
        read_trace(2, 4, "h_trace2");
        read_trace(3, 0, "h_trace3");
        read_trace(4, 0, "h_trace4");

        // Scenario 4: ten distinct pcs wrap the trace
        start_run();
        for (int i = 0; i < 10; i++) begin
            pc = 32'(4 * i);
            tick();
        end
        check("wrap_cycle", cycle_count, 10);
        read_trace(0, 36, "wrap_trace0");
        read_trace(7, 8, "wrap_trace7");

        // Scenario 5: reset asserted mid-run
        start_run();
        for (int i = 0; i < 20; i++) begin
            pc = 32'(100 + 4 * i);
            tick();
        end
        check("mr_pre_cycle", cycle_count, 20);
        check("mr_pre_state", state, 1);
        reset = 1'b1;
        tick();
        check("mr_state", state, 0);
        check("mr_core_reset", core_reset, 1);
        check("mr_cycle", cycle_count, 0);
        check("mr_last_pc", last_pc, 0);
        read_trace(0, 0, "mr_trace0");
        read_trace(3, 0, "mr_trace3");
        reset = 1'b0;
        tick();
        check("mr_hold1_core_reset", core_reset, 1);
        check("mr_hold1_state", state, 0);
        tick();
        check("mr_hold2_core_reset", core_reset, 0);
        check("mr_hold2_state", state, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
